// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and presents
// fetched words to decode over valid/ready. Optional counters under FETCH_PERF_EN.
module fetch_stage #(
  parameter int          ROM_DEPTH = 12,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] plus4_q, plus4_d;

  logic slot_free;
  logic in_range;
  logic br_lsb_unused;

  assign slot_free     = !valid_q || id_ready;
  assign in_range      = pc_q[31:2] < 30'(ROM_DEPTH);
  assign br_lsb_unused = ^br_target[1:0];

  // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    plus4_d = plus4_q;
    if (br_taken) begin
      // Redirect wins over stall and end-of-program; the wrong-path word is dropped.
      pc_d    = {br_target[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_FILL: state_d = S_RUN;
        S_RUN: begin
          if (slot_free) begin
            if (in_range) begin
              instr_d = rom_data;
              ifpc_d  = pc_q;
              plus4_d = pc_q + 32'd4;
              valid_d = 1'b1;
              pc_d    = pc_q + 32'd4;
            end else begin
              valid_d = 1'b0;
              state_d = S_HALT;
            end
          end
        end
        S_HALT:  valid_d = 1'b0;
        default: state_d = S_FILL;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      plus4_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      plus4_q <= plus4_d;
    end
  end

  assign rom_addr    = pc_q[ADDR_W+1:2];
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = plus4_q;
  assign halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (valid_q && id_ready)  issued_q <= issued_q + 32'd1;
      if (valid_q && !id_ready) stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that owns the program counter. It drives the word address into the 64×32 instruction ROM and captures the returned word into a fetch/decode pipeline register. The pipeline register is presented to decode through a valid/ready handshake. Execute can redirect the stage with a branch, and the stage halts when the PC walks past the populated ROM region.

## Interface

Parameters:
- ROM_DEPTH, 12: number of populated ROM words. Word index >= ROM_DEPTH means end of program.
- ADDR_W, 6: ROM word-address width.
- RESET_PC, 32'h0000_0000: byte PC loaded on reset. Bits [1:0] must be 0.

Ports:
- clk  in  1: single clock. All state updates happen on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- rom_addr  out  ADDR_W: equals pc_q[ADDR_W+1:2]. It is combinational from the PC register.
- rom_data  in  32: ROM output. The ROM registers on the falling edge of clk, so the word for rom_addr is stable at the next rising edge.
- br_taken  in  1: redirect request from execute.
- br_target  in  32: byte target address. Bits [1:0] are ignored (forced to 0).
- id_ready  in  1: decode can accept the current instruction.
- if_valid  out  1: if_instr and if_pc hold a valid instruction.
- if_instr  out  32: fetched instruction word.
- if_pc  out  32: byte address of if_instr.
- if_pc_plus4  out  32: if_pc + 4. This is a registered copy, not computed combinationally.
- halted  out  1: stage is in HALT.
- perf_issued  out  32: count of instructions accepted by decode. Present only with FETCH_PERF_EN.
- perf_stall  out  32: count of stall cycles. Present only with FETCH_PERF_EN.

## Operation

- Reset values:
  - pc_q = RESET_PC.
  - state = FILL.
  - if_valid = 0, if_instr = 0, if_pc = 0, if_pc_plus4 = 0.
  - halted = 0.
  - Perf counters = 0.
- Handshake:
  - "accept" = if_valid & id_ready.
  - "slot free" = !if_valid | id_ready.
  - While if_valid = 1 and id_ready = 0, if_instr, if_pc, if_pc_plus4 and pc_q hold unchanged.
- States:
  - FILL: covers exactly one cycle after reset release. It guarantees the ROM has seen one falling edge with rom_addr = RESET_PC. At the next edge go to RUN. Nothing is issued.
  - RUN, slot free, word index pc_q[31:2] < ROM_DEPTH:
    - if_instr <= rom_data, if_pc <= pc_q, if_pc_plus4 <= pc_q + 4, if_valid <= 1.
    - pc_q <= pc_q + 4.
  - RUN, slot free, word index >= ROM_DEPTH: if_valid <= 0, state <= HALT, halted <= 1.
  - RUN, slot not free: hold everything.
  - HALT: pc_q and outputs hold, and if_valid = 0. Only br_taken or rst leaves HALT.
- Branch, which has priority over stall and end-of-program in every state:
  - pc_q <= {br_target[31:2], 2'b00}.
  - if_valid <= 0: the in-flight wrong-path word is flushed even if decode was stalled.
  - state <= RUN, halted <= 0.
- PC arithmetic is modulo 2^32. The upper bits are not checked beyond the ROM_DEPTH comparison on pc_q[31:2].

## Timing

- Fetch latency: an instruction appears on if_* on the first rising edge after pc_q takes its address. The sustained rate is one instruction per cycle with id_ready held high.
- After rst deasserts, the FILL edge is edge 1. The first if_valid = 1, for RESET_PC, comes at edge 2.
- Branch redirect:
  - The edge that samples br_taken produces if_valid = 0.
  - The next edge issues the target instruction.
  - This is exactly one bubble cycle.
- When br_taken coincides with a stalled valid instruction, that instruction is dropped and is not counted as issued.
- Reset asserted at any point, including mid-stall or in HALT, forces all reset values immediately, without waiting for a clock edge.

## Configuration

- FETCH_PERF_EN defined:
  - perf_issued increments on every accept.
  - perf_stall increments on every cycle with if_valid & !id_ready.
  - Both counters wrap at 2^32 and are cleared by rst.
- FETCH_PERF_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan

The plan uses the default ROM contents.
- Reset, then run with id_ready = 1:
  - Edge 2 gives if_instr = 32'h13a0000c, if_pc = 0.
  - Edge 3 gives 32'he3a01004, if_pc = 4.
  - Edge 4 gives 32'h33a05000, if_pc = 8.
- Hold id_ready = 0 for 3 cycles while if_pc = 8:
  - if_instr stays 32'h33a05000 and rom_addr stays 3.
  - After release, the next instruction is 32'ha3a01001 at if_pc = 12.
- Assert br_taken with br_target = 32'h23 while stalled:
  - The next cycle shows if_valid = 0.
  - The cycle after shows if_instr = 32'h2afffffc, if_pc = 32'h20, if_pc_plus4 = 32'h24.
- Free-run to the end of the program:
  - The last issued instruction is 32'he1016090 at if_pc = 32'h2c.
  - On the next edge halted = 1 and if_valid = 0, and both hold for 5 cycles.
  - br_taken to 0 then clears halted and issues 32'h13a0000c.
- Assert rst asynchronously between edges during a stall: if_valid, halted and pc-derived rom_addr drop to 0 before the next clock edge.
- With FETCH_PERF_EN: 12 instructions with 3 stall cycles end with perf_issued = 12 and perf_stall = 3.
